// File: rtl/vga_stream_capture.sv
// VGA receive-side capture: recovers line/frame timing from the DAC-bound stream,
// locks to a fixed mode and streams active pixels with x/y through a small FIFO.
module vga_stream_capture #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        blank_n,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_color,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        locked,
    output logic        timing_err,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        overflow
);

    localparam int unsigned CW = 10;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = AW + 1;
    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic          hs1, vs1, bl1, hs1_d, vs1_d;
    logic [7:0]    r1, g1, b1;
    logic          line_start, frame_start;
    logic [CW-1:0] hcnt, xcnt, vcnt, ycnt;
    logic [CW-1:0] hcnt_inc, xcnt_inc, vcnt_inc, ycnt_inc;
    logic [CW-1:0] lines_seen, rows_seen;
    logic          lines_ok, line_good, line_bad, frame_good;
    state_t        state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic          err_n;

    logic [23:0]   mem_color [FIFO_DEPTH];
    logic [CW-1:0] mem_x     [FIFO_DEPTH];
    logic [CW-1:0] mem_y     [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_n;
    logic          cap_req, full, do_rd, do_wr;

    // Input stage S1 plus previous sync values for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            bl1   <= 1'b0;
            hs1_d <= 1'b1;
            vs1_d <= 1'b1;
            r1    <= '0;
            g1    <= '0;
            b1    <= '0;
        end else begin
            hs1   <= hsync_n;
            vs1   <= vsync_n;
            bl1   <= blank_n;
            hs1_d <= hs1;
            vs1_d <= vs1;
            r1    <= red;
            g1    <= green;
            b1    <= blue;
        end
    end

    assign line_start  = hs1_d & ~hs1;
    assign frame_start = vs1_d & ~vs1;

    assign hcnt_inc = (hcnt == CMAX) ? hcnt : hcnt + CW'(1);
    assign xcnt_inc = (xcnt == CMAX) ? xcnt : xcnt + CW'(1);
    assign vcnt_inc = (vcnt == CMAX) ? vcnt : vcnt + CW'(1);
    assign ycnt_inc = (ycnt == CMAX) ? ycnt : ycnt + CW'(1);

    // A line finishing on the same cycle as frame start still belongs to the ending frame
    assign line_good  = (hcnt_inc == CW'(H_TOTAL)) && (xcnt == '0 || xcnt == CW'(H_ACTIVE));
    assign line_bad   = line_start && !line_good;
    assign lines_seen = line_start ? vcnt_inc : vcnt;
    assign rows_seen  = (line_start && xcnt != '0) ? ycnt_inc : ycnt;
    assign frame_good = lines_ok && !line_bad &&
                        (lines_seen == CW'(V_TOTAL)) && (rows_seen == CW'(V_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            xcnt        <= '0;
            vcnt        <= '0;
            ycnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            lines_ok    <= 1'b0;
        end else begin
            hcnt <= line_start ? '0 : hcnt_inc;
            if (line_start) line_len <= hcnt_inc;
            xcnt <= line_start ? '0 : (bl1 ? xcnt_inc : xcnt);
            if (frame_start) begin
                frame_lines <= lines_seen;
                vcnt        <= '0;
                ycnt        <= '0;
                lines_ok    <= 1'b1;
            end else if (line_start) begin
                vcnt <= vcnt_inc;
                ycnt <= rows_seen;
                if (line_bad) lines_ok <= 1'b0;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state      <= state_n;
            good_cnt   <= good_n;
            locked     <= (state_n == LOCKED);
            timing_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        err_n   = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_start) begin
                    state_n = MEASURE;
                    good_n  = '0;
                end
            end
            MEASURE: begin
                if (frame_start) begin
                    if (frame_good) begin
                        good_n = good_cnt + GW'(1);
                        if (good_n == GW'(LOCK_FRAMES)) state_n = LOCKED;
                    end else begin
                        good_n = '0;
                        err_n  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if ((frame_start && !frame_good) || hcnt == CMAX || vcnt == CMAX) begin
                    err_n   = 1'b1;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // Output FIFO; a write into a full FIFO is accepted only when the head leaves the same cycle
    assign cap_req = (state == LOCKED) && bl1 && (xcnt < CW'(H_ACTIVE)) && (ycnt < CW'(V_ACTIVE));
    assign full    = (count == NW'(FIFO_DEPTH));
    assign do_rd   = pix_valid && pix_ready;
    assign do_wr   = cap_req && (!full || do_rd);

    always_comb begin
        count_n = count;
        case ({do_wr, do_rd})
            2'b10:   count_n = count + NW'(1);
            2'b01:   count_n = count - NW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pix_valid <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_color[i] <= '0;
                mem_x[i]     <= '0;
                mem_y[i]     <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_color[wr_ptr] <= {b1, g1, r1};
                mem_x[wr_ptr]     <= xcnt;
                mem_y[wr_ptr]     <= ycnt;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            pix_valid <= (count_n != '0);
            if (cap_req && full && !do_rd) overflow <= 1'b1;
        end
    end

    assign pix_color = mem_color[rd_ptr];
    assign pix_x     = mem_x[rd_ptr];
    assign pix_y     = mem_y[rd_ptr];

endmodule
